// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode, state and select-index definitions for the ALU op sequencer.
// Imported by the decoder and the top.
package alu_seq_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int REP_W_DEF  = 4;
    localparam int SETTLE_DEF = 1;

    localparam logic [2:0] OP_ADD        = 3'd0;
    localparam logic [2:0] OP_SUB        = 3'd1;
    localparam logic [2:0] OP_INC        = 3'd2;
    localparam logic [2:0] OP_DEC        = 3'd3;
    localparam logic [2:0] OP_NEG        = 3'd4;
    localparam logic [2:0] OP_CMP        = 3'd5;
    localparam logic [2:0] OP_ILLEGAL_LO = 3'd6;

    // Bit positions inside the one-hot select vector
    localparam int SEL_DEC = 0;
    localparam int SEL_INC = 1;
    localparam int SEL_ADD = 2;
    localparam int SEL_SUB = 3;
    localparam int SEL_CMP = 4;
    localparam int SEL_NEG = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// Opcode -> one-hot ALU select vector, forced to zero when en is low.
// illegal reflects the opcode alone, independent of en.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic       en,
    input  logic [2:0] op,
    output logic [5:0] sel,
    output logic       illegal
);

    always_comb begin
        sel     = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  sel[SEL_ADD] = 1'b1;
            OP_SUB:  sel[SEL_SUB] = 1'b1;
            OP_INC:  sel[SEL_INC] = 1'b1;
            OP_DEC:  sel[SEL_DEC] = 1'b1;
            OP_NEG:  sel[SEL_NEG] = 1'b1;
            OP_CMP:  sel[SEL_CMP] = 1'b1;
            default: illegal      = 1'b1;
        endcase
        if (!en) begin
            sel = '0;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences the arithmetic ALU: accepts a command, iterates it with result feedback,
// holding each select SETTLE_CYCLES cycles, then presents a held response.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int SETTLE_CYCLES = SETTLE_DEF,
    parameter int REP_W         = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [REP_W-1:0] cmd_rep,
    output logic             alu_dec,
    output logic             alu_inc,
    output logic             alu_add,
    output logic             alu_sub,
    output logic             alu_cmp,
    output logic             alu_neg,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_c_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             res_err
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d, b_q, b_d, last_q, last_d;
    logic [REP_W-1:0] rep_q, rep_d, step_q, step_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             carry_q, carry_d, err_q, err_d;
    logic [5:0]       sel_q, sel_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic             res_valid_q, res_valid_d, res_carry_q, res_carry_d;
    logic             res_zero_q, res_zero_d, res_err_q, res_err_d;
    logic [WIDTH-1:0] res_data_q, res_data_d, fin;

    logic       capture, last_step, dec_en, dec_illegal;
    logic [2:0] dec_op;
    logic [5:0] dec_sel;

    assign capture   = (state_q == ST_EXEC) && (settle_q == SW'(SETTLE_CYCLES - 1));
    assign last_step = capture && (step_q == rep_q);
    // Enable is derived without the illegal flag; the decoder zeroes selects for illegal ops
    assign dec_en    = ((state_q == ST_IDLE) && cmd_valid) || ((state_q == ST_EXEC) && !last_step);
    assign dec_op    = (state_q == ST_IDLE) ? cmd_op : op_q;

    alu_op_decode u_decode (
        .en      (dec_en),
        .op      (dec_op),
        .sel     (dec_sel),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        b_d         = b_q;
        last_d      = last_q;
        rep_d       = rep_q;
        step_d      = step_q;
        settle_d    = settle_q;
        carry_d     = carry_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        res_err_d   = res_err_q;
        fin         = err_q ? '0 : last_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    acc_d    = cmd_a;
                    b_d      = cmd_b;
                    rep_d    = cmd_rep;
                    step_d   = '0;
                    settle_d = '0;
                    carry_d  = 1'b0;
                    err_d    = dec_illegal;
                    state_d  = dec_illegal ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (capture) begin
                    settle_d = '0;
                    last_d   = alu_sum;
                    carry_d  = carry_q | alu_c_out;
                    if (op_q != OP_CMP) begin
                        acc_d = alu_sum;
                    end
                    if (last_step) begin
                        state_d = ST_RESP;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                    res_data_d  = fin;
                    res_carry_d = carry_q & ~err_q;
                    res_zero_d  = (fin == '0);
                    res_err_d   = err_q;
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        sel_d   = dec_sel;
        alu_a_d = (state_d == ST_EXEC) ? acc_d : '0;
        alu_b_d = (state_d == ST_EXEC) ? b_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            last_q      <= '0;
            rep_q       <= '0;
            step_q      <= '0;
            settle_q    <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            sel_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            last_q      <= last_d;
            rep_q       <= rep_d;
            step_q      <= step_d;
            settle_q    <= settle_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            sel_q       <= sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
            res_err_q   <= res_err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign alu_dec   = sel_q[SEL_DEC];
    assign alu_inc   = sel_q[SEL_INC];
    assign alu_add   = sel_q[SEL_ADD];
    assign alu_sub   = sel_q[SEL_SUB];
    assign alu_cmp   = sel_q[SEL_CMP];
    assign alu_neg   = sel_q[SEL_NEG];
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_zero  = res_zero_q;
    assign res_err   = res_err_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-driven controller that sequences the 8-bit arithmetic ALU (one-hot selects dec/inc/add/sub/cmp/neg, result sum plus c_out).
- Accepts one command per valid/ready handshake.
- Drives exactly one ALU select per step and holds it for a settle window.
- Iterates the operation with the registered result fed back into operand a, then returns the result and flags on a valid/ready response port.
- Sits between the instruction decode logic and alu_arithmetic; it is the only driver of the ALU select lines.

Parameters:
WIDTH, 8, operand/result width (matches ALU)
SETTLE_CYCLES, 1, cycles each select is held before sum/c_out is captured (>=1)
REP_W, 4, width of iteration count field

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 NEG, 5 CMP, 6-7 illegal
cmd_a  in  WIDTH  operand a (first iteration)
cmd_b  in  WIDTH  operand b (all iterations)
cmd_rep  in  REP_W  iterations minus one (0 -> 1 iteration, 15 -> 16)
alu_dec, alu_inc, alu_add, alu_sub, alu_cmp, alu_neg  out  1 each  ALU one-hot selects
alu_a  out  WIDTH  ALU operand a
alu_b  out  WIDTH  ALU operand b
alu_sum  in  WIDTH  ALU result (combinational from selects/operands)
alu_c_out  in  1  ALU carry out
res_valid  out  1  response present
res_ready  in  1  consumer accepts response
res_data  out  WIDTH  final result
res_carry  out  1  OR of alu_c_out over all iterations
res_zero  out  1  res_data == 0
res_err  out  1  illegal opcode

Behaviour:
- Reset (clk edge with rst=1), from any state including mid-EXEC:
  - state IDLE, all six selects 0, alu_a/alu_b 0.
  - res_valid 0, res_data 0, res_carry/res_zero/res_err 0.
  - cmd_ready 1 from the first non-reset cycle.
- Clock and reset: single clock; reset is synchronous, active-high (clk, rst).
- States: IDLE, EXEC, RESP. cmd_ready = (state==IDLE); it is never asserted in EXEC or RESP.
- IDLE:
  - Handshake (cmd_valid & cmd_ready) latches op, a, b, rep.
  - Clears the sticky carry and the step/settle counters.
  - Legal op -> EXEC. Illegal op -> RESP with res_err=1, res_data=0, res_carry=0, res_zero=1, and no select ever asserted.
- EXEC:
  - Exactly one select is high, decoded from op; alu_a = (step==0 ? cmd_a : acc); alu_b = cmd_b.
  - Operands and selects are registered outputs, stable for the whole settle window.
  - The settle counter runs 0..SETTLE_CYCLES-1. On the last settle cycle, alu_sum and alu_c_out are captured: acc <= alu_sum (except CMP: acc unchanged, equal to cmd_a after step 0), carry_sticky |= alu_c_out, step++.
  - After step == rep completes -> RESP; selects drop to 0 on the same edge.
- Selects deassert for zero cycles between iterations of one command (they stay high).
- RESP:
  - res_valid=1; res_data = result of the final capture (CMP: the final alu_sum), res_carry = sticky carry, res_zero computed from res_data.
  - Outputs are held stable while res_ready=0 (unbounded backpressure).
  - res_valid & res_ready -> IDLE; res_valid drops on the next edge.
  - The next command is accepted at the earliest one cycle after the response handshake.
- Latency with SETTLE_CYCLES=1, rep=0: command accepted at edge T; select high during cycle T..T+1; res_valid high after edge T+2. In general, res_valid rises (rep+1)*SETTLE_CYCLES+1 edges after acceptance.
- Arithmetic: all WIDTH-bit, modulo 2^WIDTH; the sequencer performs no arithmetic itself except counters.
- Invariant: at most one of the six selects is high in any cycle; all six are 0 outside EXEC.

Decomposition:
- Package alu_seq_pkg: opcode constants (OP_ADD..OP_CMP, OP_ILLEGAL range), state encoding (ST_IDLE/ST_EXEC/ST_RESP), WIDTH/REP_W defaults.
- One sub-module, alu_op_decode: combinational opcode -> 6-bit one-hot select vector plus illegal flag, gated by an enable input (EXEC).
- Counters, accumulator and FSM stay in the top.

Test Plan:
- Basic ADD: cmd_a=0xAA, cmd_b=0xD5, rep=0 -> alu_add high exactly 1 cycle, res_data=0x7F, res_carry=1, res_zero=0; res_valid 2 edges after acceptance.
- Iterated ADD: a=0x03, b=0x05, rep=2 -> alu_add high 3 consecutive cycles, alu_a sequence 0x03,0x08,0x0D, res_data=0x12, res_carry=0.
- INC wrap: a=0xFE, rep=3, SETTLE_CYCLES=3 -> sums FF,00,01,02; res_data=0x02, res_carry=1 (sticky); each alu_a value held 3 cycles; total EXEC 12 cycles.
- Backpressure: after ADD response, hold res_ready=0 for 5 cycles with cmd_valid=1 -> res_data/flags unchanged, cmd_ready=0 throughout, next command accepted only after the response handshake.
- Illegal op 7 -> no select ever high, res_err=1, res_data=0, res_zero=1; following legal SUB completes normally with res_err=0.
- Reset mid-operation: rst=1 during the second iteration of a rep=5 ADD -> next cycle all selects 0, res_valid=0, cmd_ready=1 after rst drops; a fresh command then produces a correct result (no stale carry or accumulator).
